// File: rtl/blast_spread.sv
// -----------------------------------------------------------------------------
// blast_spread
//   Turns the bomb controller's one-cycle blast pulse into a cross-shaped
//   flame. The bomb cell is latched as the flame centre. Each arm (up, down,
//   left, right) then grows by one cell per growth step, up to RANGE cells.
//   Every candidate cell is checked against the wall map first. An arm stops
//   at the first wall or at the playfield edge. The finished flame is held
//   for HOLD_FRAMES frames and then cleared.
//
// Ports
//   clk, resetN          system clock, asynchronous active-low reset
//   startOfFrame         one-cycle pulse per video frame (paces growth/hold)
//   blast                one-cycle explosion pulse
//   bomb_topLeftX/Y      bomb top-left pixel position, sampled with blast
//   pixelX/Y             current VGA pixel
//   map_req              one-cycle wall-map lookup strobe
//   map_col/map_row      lookup cell, held through the response cycle
//   map_wall             lookup result, valid the cycle after map_req
//   flame_DR             drawing request for the current pixel (combinational)
//   flame_active         explosion in progress
//   reach_up/down/left/right  current arm lengths in cells
//   busy                 controller is not idle
// -----------------------------------------------------------------------------
module blast_spread #(
  parameter int CELL_LOG2   = 5,
  parameter int RANGE       = 3,
  parameter int STEP_FRAMES = 4,
  parameter int HOLD_FRAMES = 30,
  parameter int GRID_COLS   = 20,
  parameter int GRID_ROWS   = 15
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               blast,
  input  logic signed [10:0] bomb_topLeftX,
  input  logic signed [10:0] bomb_topLeftY,
  input  logic        [10:0] pixelX,
  input  logic        [10:0] pixelY,
  output logic               map_req,
  output logic        [4:0]  map_col,
  output logic        [3:0]  map_row,
  input  logic               map_wall,
  output logic               flame_DR,
  output logic               flame_active,
  output logic        [1:0]  reach_up,
  output logic        [1:0]  reach_down,
  output logic        [1:0]  reach_left,
  output logic        [1:0]  reach_right,
  output logic               busy
);

  localparam int CNT_MAX = (HOLD_FRAMES > STEP_FRAMES) ? HOLD_FRAMES : STEP_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(STEP_FRAMES);
  localparam logic [1:0]       RANGE_L  = 2'(RANGE);
  localparam logic signed [6:0] COLS_S  = 7'(GRID_COLS);
  localparam logic signed [6:0] ROWS_S  = 7'(GRID_ROWS);

  // Direction encoding doubles as the index into reach_r / blocked_r.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_QUERY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STEP  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t               state_r,        state_nxt_s;
  logic [1:0]           dir_r,          dir_nxt_s;
  logic [4:0]           center_col_r,   center_col_nxt_s;
  logic [3:0]           center_row_r,   center_row_nxt_s;
  logic [3:0][1:0]      reach_r,        reach_nxt_s;
  logic [3:0]           blocked_r,      blocked_nxt_s;
  logic [CNT_W-1:0]     cnt_r,          cnt_nxt_s;
  logic [4:0]           map_col_r,      map_col_nxt_s;
  logic [3:0]           map_row_r,      map_row_nxt_s;
  logic                 flame_active_r, flame_active_nxt_s;
  logic                 busy_r,         busy_nxt_s;

  logic [10:0]          bx_cell_s, by_cell_s;
  logic                 accept_s;
  logic signed [6:0]    c_col_s, c_row_s, step_s, tgt_col_s, tgt_row_s;
  logic                 tgt_in_grid_s, at_range_s, skip_s;
  logic                 pass_end_s, all_done_s;

  // Bomb position to cell index; a negative position is rejected by its sign bit.
  assign bx_cell_s = $unsigned(bomb_topLeftX) >> CELL_LOG2;
  assign by_cell_s = $unsigned(bomb_topLeftY) >> CELL_LOG2;
  assign accept_s  = (state_r == ST_IDLE) && blast &&
                     !bomb_topLeftX[10] && !bomb_topLeftY[10] &&
                     (bx_cell_s < 11'(GRID_COLS)) && (by_cell_s < 11'(GRID_ROWS));

  // Candidate cell for the current direction, in 7-bit signed so that an
  // arm leaving row/column 0 goes negative instead of wrapping.
  assign c_col_s = $signed({2'b00, center_col_r});
  assign c_row_s = $signed({3'b000, center_row_r});
  assign step_s  = $signed({5'b00000, reach_r[dir_r]}) + 7'sd1;

  // Target cell offset from the centre along the current direction.
  always_comb begin
    tgt_col_s = c_col_s;
    tgt_row_s = c_row_s;
    case (dir_r)
      DIR_UP:    tgt_row_s = c_row_s - step_s;
      DIR_DOWN:  tgt_row_s = c_row_s + step_s;
      DIR_LEFT:  tgt_col_s = c_col_s - step_s;
      DIR_RIGHT: tgt_col_s = c_col_s + step_s;
      default:   tgt_col_s = c_col_s;
    endcase
  end

  assign tgt_in_grid_s = (tgt_col_s >= 7'sd0) && (tgt_col_s < COLS_S) &&
                         (tgt_row_s >= 7'sd0) && (tgt_row_s < ROWS_S);
  assign at_range_s    = (reach_r[dir_r] == RANGE_L);
  assign skip_s        = blocked_r[dir_r] || at_range_s || !tgt_in_grid_s;

  // Next-state and datapath updates for the spread controller.
  always_comb begin
    state_nxt_s        = state_r;
    dir_nxt_s          = dir_r;
    center_col_nxt_s   = center_col_r;
    center_row_nxt_s   = center_row_r;
    reach_nxt_s        = reach_r;
    blocked_nxt_s      = blocked_r;
    cnt_nxt_s          = cnt_r;
    map_col_nxt_s      = map_col_r;
    map_row_nxt_s      = map_row_r;
    flame_active_nxt_s = flame_active_r;
    busy_nxt_s         = busy_r;
    pass_end_s         = 1'b0;
    all_done_s         = 1'b1;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s        = ST_QUERY;
          dir_nxt_s          = DIR_UP;
          center_col_nxt_s   = bx_cell_s[4:0];
          center_row_nxt_s   = by_cell_s[3:0];
          reach_nxt_s        = '0;
          blocked_nxt_s      = 4'b0000;
          flame_active_nxt_s = 1'b1;
          busy_nxt_s         = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_QUERY: begin
        if (skip_s) begin
          if (!tgt_in_grid_s) begin
            blocked_nxt_s[dir_r] = 1'b1;
          end else begin
            blocked_nxt_s[dir_r] = blocked_r[dir_r];
          end
          dir_nxt_s  = dir_r + 2'd1;
          pass_end_s = (dir_r == DIR_RIGHT);
        end else begin
          map_col_nxt_s = tgt_col_s[4:0];
          map_row_nxt_s = tgt_row_s[3:0];
          state_nxt_s   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (map_wall) begin
          blocked_nxt_s[dir_r] = 1'b1;
        end else begin
          reach_nxt_s[dir_r] = reach_r[dir_r] + 2'd1;
        end
        dir_nxt_s   = dir_r + 2'd1;
        state_nxt_s = ST_QUERY;
        pass_end_s  = (dir_r == DIR_RIGHT);
      end
      ST_STEP: begin
        if (cnt_r == '0) begin
          state_nxt_s = ST_QUERY;
          dir_nxt_s   = DIR_UP;
        end else if (startOfFrame) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_HOLD: begin
        if (cnt_r == '0) begin
          state_nxt_s        = ST_IDLE;
          flame_active_nxt_s = 1'b0;
          busy_nxt_s         = 1'b0;
          reach_nxt_s        = '0;
        end else if (startOfFrame) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // The pass is finished once every arm is blocked or at full length.
    for (int i = 0; i < 4; i++) begin
      if (!(blocked_nxt_s[i] || (reach_nxt_s[i] == RANGE_L))) begin
        all_done_s = 1'b0;
      end else begin
        all_done_s = all_done_s;
      end
    end

    if (pass_end_s) begin
      if (all_done_s) begin
        state_nxt_s = ST_HOLD;
        cnt_nxt_s   = HOLD_CNT;
      end else begin
        state_nxt_s = ST_STEP;
        cnt_nxt_s   = STEP_CNT;
      end
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r        <= ST_IDLE;
      dir_r          <= DIR_UP;
      center_col_r   <= 5'd0;
      center_row_r   <= 4'd0;
      reach_r        <= '0;
      blocked_r      <= 4'b0000;
      cnt_r          <= '0;
      map_col_r      <= 5'd0;
      map_row_r      <= 4'd0;
      flame_active_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      dir_r          <= dir_nxt_s;
      center_col_r   <= center_col_nxt_s;
      center_row_r   <= center_row_nxt_s;
      reach_r        <= reach_nxt_s;
      blocked_r      <= blocked_nxt_s;
      cnt_r          <= cnt_nxt_s;
      map_col_r      <= map_col_nxt_s;
      map_row_r      <= map_row_nxt_s;
      flame_active_r <= flame_active_nxt_s;
      busy_r         <= busy_nxt_s;
    end
  end

  // The lookup strobe is a decode of the QUERY state, so map_wall arrives in
  // the following (WAIT) cycle; the address register keeps it stable there.
  assign map_req      = (state_r == ST_QUERY) && !skip_s;
  assign map_col      = map_req ? tgt_col_s[4:0] : map_col_r;
  assign map_row      = map_req ? tgt_row_s[3:0] : map_row_r;
  assign flame_active = flame_active_r;
  assign busy         = busy_r;
  assign reach_up     = reach_r[DIR_UP];
  assign reach_down   = reach_r[DIR_DOWN];
  assign reach_left   = reach_r[DIR_LEFT];
  assign reach_right  = reach_r[DIR_RIGHT];

  // Pixel drawing request: vertical bar plus horizontal bar through the centre.
  logic [10:0] pc_s, pr_s, cc_s, cr_s;
  logic        pix_in_grid_s, vert_s, horiz_s;

  assign pc_s = pixelX >> CELL_LOG2;
  assign pr_s = pixelY >> CELL_LOG2;
  assign cc_s = {6'd0, center_col_r};
  assign cr_s = {7'd0, center_row_r};

  assign pix_in_grid_s = (pc_s < 11'(GRID_COLS)) && (pr_s < 11'(GRID_ROWS));
  assign vert_s  = (pc_s == cc_s) &&
                   ((pr_s + {9'd0, reach_up}) >= cr_s) &&
                   (pr_s <= (cr_s + {9'd0, reach_down}));
  assign horiz_s = (pr_s == cr_s) &&
                   ((pc_s + {9'd0, reach_left}) >= cc_s) &&
                   (pc_s <= (cc_s + {9'd0, reach_right}));

  assign flame_DR = flame_active_r && pix_in_grid_s && (vert_s || horiz_s);

endmodule

// File: tb/tb_blast_spread.sv
module tb_blast_spread;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic               blast;
  logic signed [10:0] bomb_topLeftX;
  logic signed [10:0] bomb_topLeftY;
  logic        [10:0] pixelX;
  logic        [10:0] pixelY;
  logic               map_req;
  logic        [4:0]  map_col;
  logic        [3:0]  map_row;
  logic               map_wall;
  logic               flame_DR;
  logic               flame_active;
  logic        [1:0]  reach_up, reach_down, reach_left, reach_right;
  logic               busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic walls [20][15];
  logic poison;
  logic [8:0] exp_q [$];

  blast_spread dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .blast(blast),
    .bomb_topLeftX(bomb_topLeftX), .bomb_topLeftY(bomb_topLeftY),
    .pixelX(pixelX), .pixelY(pixelY),
    .map_req(map_req), .map_col(map_col), .map_row(map_row), .map_wall(map_wall),
    .flame_DR(flame_DR), .flame_active(flame_active),
    .reach_up(reach_up), .reach_down(reach_down),
    .reach_left(reach_left), .reach_right(reach_right),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int c, input int r);
    logic [4:0] cv;
    logic [3:0] rv;
    cv = c[4:0];
    rv = r[3:0];
    exp_q.push_back({cv, rv});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk);
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
    end
  endtask

  // Called on a falling edge; leaves the pulse one cycle wide.
  task automatic blast_at(input int x, input int y);
    bomb_topLeftX = 11'(x);
    bomb_topLeftY = 11'(y);
    blast = 1'b1;
    @(negedge clk);
    blast = 1'b0;
  endtask

  task automatic pix(input string name, input int x, input int y, input logic exp);
    pixelX = 11'(x);
    pixelY = 11'(y);
    #1;
    chk(name, {31'd0, flame_DR}, {31'd0, exp});
  endtask

  task automatic reaches(input string name, input logic [7:0] exp);
    chk(name, {24'd0, reach_up, reach_down, reach_left, reach_right}, {24'd0, exp});
  endtask

  // Wall-map model: answers one cycle after map_req. With poison set it
  // drives 1 during the request cycle itself, which the DUT must ignore.
  initial begin : responder
    logic pend_v, pend_w;
    pend_v   = 1'b0;
    pend_w   = 1'b0;
    map_wall = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_v) map_wall = pend_w;
      else        map_wall = poison & map_req;
      pend_v = map_req;
      pend_w = (map_col < 5'd20 && map_row < 4'd15) ? walls[map_col][map_row] : 1'b0;
    end
  end

  // Scoreboard monitor: every lookup must match the next expected cell.
  initial begin : monitor
    logic       prev_req;
    logic [4:0] held_c;
    logic [3:0] held_r;
    logic [8:0] e;
    prev_req = 1'b0;
    held_c   = 5'd0;
    held_r   = 4'd0;
    forever begin
      @(negedge clk);
      if (prev_req) begin
        chk("req_width", {31'd0, map_req}, 32'd0);
        chk("hold_col",  {27'd0, map_col}, {27'd0, held_c});
        chk("hold_row",  {28'd0, map_row}, {28'd0, held_r});
      end
      if (map_req) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL lookup: unexpected map_req col %0d row %0d, none expected", map_col, map_row);
        end else begin
          e = exp_q.pop_front();
          chk("lookup", {23'd0, map_col, map_row}, {23'd0, e});
        end
        held_c = map_col;
        held_r = map_row;
      end
      prev_req = map_req;
    end
  end

  initial begin : main
    resetN = 1'b0; startOfFrame = 1'b0; blast = 1'b0; poison = 1'b0;
    bomb_topLeftX = 11'sd0; bomb_topLeftY = 11'sd0; pixelX = 11'd0; pixelY = 11'd0;
    for (int c = 0; c < 20; c++) for (int r = 0; r < 15; r++) walls[c][r] = 1'b0;

    cycles(3);
    chk("rst_active", {31'd0, flame_active}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_req",    {31'd0, map_req}, 32'd0);
    chk("rst_colrow", {23'd0, map_col, map_row}, 32'd0);
    reaches("rst_reach", 8'h00);
    resetN = 1'b1;
    cycles(1);

    // Test 1: open field at cell (10,7)
    push(10,6); push(10,8); push(9,7); push(11,7);
    push(10,5); push(10,9); push(8,7); push(12,7);
    push(10,4); push(10,10); push(7,7); push(13,7);
    blast_at(320, 224);
    chk("t1_active_next", {31'd0, flame_active}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    cycles(10);
    reaches("t1_pass1", 8'b01_01_01_01);
    pix("t1_dr_up1", 325, 197, 1'b1);
    pix("t1_dr_up2", 325, 165, 1'b0);
    frames(4); cycles(10);
    reaches("t1_pass2", 8'b10_10_10_10);
    frames(4); cycles(10);
    reaches("t1_pass3", 8'b11_11_11_11);
    pix("t1_dr_up3",  325, 133, 1'b1);
    pix("t1_dr_up4",  325, 101, 1'b0);
    pix("t1_dr_rt3",  421, 229, 1'b1);
    pix("t1_dr_rt4",  453, 229, 1'b0);
    pix("t1_dr_lf3",  229, 229, 1'b1);
    pix("t1_dr_diag", 357, 197, 1'b0);
    frames(29);
    chk("t1_hold29", {31'd0, flame_active}, 32'd1);
    frames(1); cycles(2);
    chk("t1_done_active", {31'd0, flame_active}, 32'd0);
    chk("t1_done_busy", {31'd0, busy}, 32'd0);
    reaches("t1_done_reach", 8'h00);
    pix("t1_dr_idle", 325, 229, 1'b0);
    chk("t1_queue", exp_q.size(), 32'd0);

    // Test 2: walls at (10,6) and (12,7)
    walls[10][6] = 1'b1; walls[12][7] = 1'b1;
    push(10,6); push(10,8); push(9,7); push(11,7);
    push(10,9); push(8,7); push(12,7);
    push(10,10); push(7,7);
    blast_at(320, 224);
    cycles(10);
    reaches("t2_pass1", 8'b00_01_01_01);
    frames(4); cycles(10);
    reaches("t2_pass2", 8'b00_10_10_01);
    frames(4); cycles(10);
    reaches("t2_pass3", 8'b00_11_11_01);
    frames(30); cycles(2);
    chk("t2_done_busy", {31'd0, busy}, 32'd0);
    chk("t2_queue", exp_q.size(), 32'd0);
    walls[10][6] = 1'b0; walls[12][7] = 1'b0;

    // Test 3: top-left corner
    push(0,1); push(1,0); push(0,2); push(2,0); push(0,3); push(3,0);
    blast_at(0, 0);
    cycles(10);
    reaches("t3_pass1", 8'b00_01_00_01);
    frames(4); cycles(10);
    frames(4); cycles(10);
    reaches("t3_pass3", 8'b00_11_00_11);
    pix("t3_dr_row3", 5, 100, 1'b1);
    pix("t3_dr_row4", 5, 130, 1'b0);
    pix("t3_dr_col3", 100, 5, 1'b1);
    pix("t3_dr_col4", 130, 5, 1'b0);
    frames(30); cycles(2);
    chk("t3_done_busy", {31'd0, busy}, 32'd0);

    // Test 3b: bottom-right corner cell (19,14)
    push(19,13); push(18,14); push(19,12); push(17,14); push(19,11); push(16,14);
    blast_at(608, 448);
    cycles(10); frames(4); cycles(10); frames(4); cycles(10);
    reaches("t3b_pass3", 8'b11_00_11_00);
    pix("t3b_dr_off", 640, 453, 1'b0);
    frames(30); cycles(2);
    chk("t3b_queue", exp_q.size(), 32'd0);

    // Test 4: parked bomb is ignored; a blast while busy is ignored
    blast_at(640, 480);
    cycles(2);
    chk("t4_parked_busy", {31'd0, busy}, 32'd0);
    chk("t4_parked_active", {31'd0, flame_active}, 32'd0);
    poison = 1'b1;
    push(5,2); push(5,4); push(4,3); push(6,3);
    push(5,1); push(5,5); push(3,3); push(7,3);
    push(5,0); push(5,6); push(2,3); push(8,3);
    blast_at(160, 96);
    cycles(9);
    blast_at(0, 0);
    cycles(2);
    reaches("t4_reach_kept", 8'b01_01_01_01);
    pix("t4_center_kept", 165, 101, 1'b1);
    pix("t4_new_center", 5, 5, 1'b0);
    frames(4); cycles(10); frames(4); cycles(10);
    reaches("t4_full", 8'b11_11_11_11);
    chk("t4_queue", exp_q.size(), 32'd0);

    // Test 5: asynchronous reset during HOLD, then a fresh blast
    pixelX = 11'd165; pixelY = 11'd101;
    resetN = 1'b0;
    #1;
    chk("t5_active", {31'd0, flame_active}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_req", {31'd0, map_req}, 32'd0);
    chk("t5_colrow", {23'd0, map_col, map_row}, 32'd0);
    chk("t5_dr", {31'd0, flame_DR}, 32'd0);
    reaches("t5_reach", 8'h00);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    push(10,6); push(10,8); push(9,7); push(11,7);
    blast_at(320, 224);
    chk("t5_reaccept", {31'd0, flame_active}, 32'd1);
    cycles(10);
    reaches("t5_pass1", 8'b01_01_01_01);
    resetN = 1'b0;
    cycles(2);
    chk("t5_queue", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blast_spread.md
Name: blast_spread

Overview:
Downstream consumer of the bomb controller's one-cycle blast pulse and bomb top-left coordinates. Latches the bomb cell and grows a cross-shaped flame outward in four directions, one cell per step. Each step queries the wall map, and an arm stops at a wall or at the grid edge. Drives a per-pixel flame drawing request for the VGA mux and a flame_active flag for collision logic. Clears itself after a hold period.

Parameters:
CELL_LOG2, 5, log2 of cell size in pixels (32 px cells)
RANGE, 3, maximum arm length in cells (1..3)
STEP_FRAMES, 4, frames between growth steps
HOLD_FRAMES, 30, frames the full flame persists before clearing
GRID_COLS, 20, playfield width in cells
GRID_ROWS, 15, playfield height in cells

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame
blast  in  1  one-cycle explosion pulse from the bomb controller
bomb_topLeftX  in  11 signed  bomb top-left X, sampled only with blast
bomb_topLeftY  in  11 signed  bomb top-left Y, sampled only with blast
pixelX  in  11  current VGA pixel X
pixelY  in  11  current VGA pixel Y
map_req  out  1  one-cycle wall-map lookup strobe
map_col  out  5  lookup column
map_row  out  4  lookup row
map_wall  in  1  lookup result, valid exactly 1 cycle after map_req
flame_DR  out  1  drawing request for the current pixel (combinational)
flame_active  out  1  explosion in progress
reach_up, reach_down, reach_left, reach_right  out  2 each  current arm lengths in cells
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, from any state, mid-operation included): state IDLE; all reaches 0; flame_active, busy, map_req 0; map_col and map_row 0; counters 0.
- Accepted blast: center col is bomb_topLeftX[10:5] and center row is bomb_topLeftY[10:5].
  - A blast pulse is accepted only in IDLE, with X and Y both non-negative, col < GRID_COLS and row < GRID_ROWS.
  - Otherwise the pulse is ignored. This covers the parked bomb at 640,480 and any blast while busy.
- States: IDLE, QUERY, WAIT, STEP, HOLD.
- IDLE -> QUERY on an accepted blast.
  - Same edge: latch the center cell, clear reaches and blocked flags, set dir=UP, set flame_active=1 and busy=1.
  - So flame_active is high on the cycle after the blast pulse.
- QUERY evaluates the current dir (order UP, DOWN, LEFT, RIGHT).
  - Skip the direction (1 cycle, advance dir) if any of these holds:
    - it is already blocked;
    - its reach == RANGE;
    - the next cell (center offset by reach+1) lies outside 0..GRID_COLS-1 or 0..GRID_ROWS-1. In this case also set its blocked flag.
  - Otherwise assert map_req for 1 cycle with map_col/map_row set to the target cell, then go to WAIT.
- WAIT: sample map_wall.
  - map_wall=1: set the direction's blocked flag; reach unchanged.
  - map_wall=0: increment the reach.
  - Then advance dir and return to QUERY.
  - map_col and map_row hold their values through WAIT.
- End of a pass (after RIGHT is processed):
  - Every direction blocked or at RANGE -> HOLD, with frame counter = HOLD_FRAMES.
  - Otherwise -> STEP, with frame counter = STEP_FRAMES.
- STEP: decrement the counter on each startOfFrame. At 0 -> QUERY with dir=UP.
- HOLD: decrement the counter on each startOfFrame. At 0 -> IDLE, with flame_active=0, busy=0 and all reaches 0.
- The first pass runs immediately after acceptance, so the first arm cells appear within 8 cycles, without waiting for a frame.
- The center cell is never looked up and is always part of the flame.
- flame_DR = flame_active AND the pixel lies in any of these areas:
  - the center cell;
  - column == center col and row in [center row - reach_up, center row + reach_down];
  - row == center row and column in [center col - reach_left, center col + reach_right].
  - Cell index is pixel[10:5]. Pixels with col >= GRID_COLS or row >= GRID_ROWS never draw.
- Arithmetic: neighbour cells are computed on 7-bit signed values so that row 0 - 1 is detected as out of grid, not wrapped.
- startOfFrame arriving during QUERY/WAIT has no effect.

Test Plan:
1. Blast with bomb at (320,224), i.e. cell (10,7), and no walls.
   -> flame_active=1 next cycle; after pass 1 all reaches = 1.
   -> Reaches = 2 after 4 startOfFrames and 3 after 8; HOLD entered.
   -> After 30 further frames, flame_active=0 and reaches=0.
2. Wall at (10,6) and (12,7), bomb at (10,7).
   -> reach_up=0 and reach_right=1 final; the other two arms reach 3.
   -> map_req is never issued again for a blocked direction.
3. Bomb at (0,0).
   -> reach_up and reach_left stay 0 with no map_req for them.
   -> Down and right grow to 3.
   -> flame_DR=1 at pixel (5,100) (row 3) and 0 at pixel (5,130) (row 4).
4. Blast with (640,480).
   -> Ignored: busy stays 0. Also: a second blast 10 cycles into an active explosion leaves the center and reaches unchanged.
5. Assert resetN low during HOLD with reaches at 3.
   -> All outputs are 0 immediately (asynchronous).
   -> A blast one cycle after release is accepted normally.
6. Check map_req timing: exactly 1 cycle wide, and map_wall is sampled on the following cycle. A map_wall=1 driven on the map_req cycle itself must be ignored.
